// File: rtl/keypad_pkg.sv
// ============================================================================
// Module   : keypad_pkg
// Purpose  : Shared key codes, scanner state encoding and row/column key map.
// Revision : 1.0
// ============================================================================
`default_nettype none

package keypad_pkg;

    localparam logic [3:0] KEY_HASH = 4'd10;
    localparam logic [3:0] KEY_STAR = 4'd11;
    localparam logic [3:0] KEY_NONE = 4'd13;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_e;

    // Rows 0-2 carry digits 1-9 in reading order; row 3 is '*', '0', '#'.
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        code = KEY_NONE;
        if (row == 2'd3) begin
            case (col)
                2'd0:    code = KEY_STAR;
                2'd1:    code = 4'd0;
                default: code = KEY_HASH;
            endcase
        end else begin
            code = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
        end
        return code;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop synchronizer for asynchronous input pins, any width.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_2ff #(
    parameter int              WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/keypad_scanner.sv
// ============================================================================
// Module   : keypad_scanner
// Purpose  : 4x3 matrix keypad scanner with debounce; one key code per press.
//            Define KEY_REPEAT_EN to emit auto-repeat codes while a key is held.
// Revision : 1.0
// ============================================================================
`default_nettype none

module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 8,
    parameter int REPEAT_SCANS = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] key_code,
    output logic       busy
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DB_W  = $clog2(DEBOUNCE_CNT + 1);

    if (SCAN_DIV < 4) begin : g_bad_scan_div
        $error("keypad_scanner: SCAN_DIV must be >= 4");
    end
    if (DEBOUNCE_CNT < 1) begin : g_bad_debounce_cnt
        $error("keypad_scanner: DEBOUNCE_CNT must be >= 1");
    end
    if (REPEAT_SCANS < 1) begin : g_bad_repeat_scans
        $error("keypad_scanner: REPEAT_SCANS must be >= 1");
    end

    logic [2:0] col_s;

    sync_2ff #(
        .WIDTH     (3),
        .RESET_VAL (3'b111)
    ) u_col_sync (
        .clk (clk),
        .rst (rst),
        .d   (col_n),
        .q   (col_s)
    );

    state_e           state_q,     state_d;
    logic [DIV_W-1:0] div_q,       div_d;
    logic [1:0]       row_idx_q,   row_idx_d;
    logic [1:0]       col_idx_q,   col_idx_d;
    logic [2:0]       col_pat_q,   col_pat_d;
    logic [DB_W-1:0]  db_cnt_q,    db_cnt_d;
    logic [3:0]       key_code_q,  key_code_d;
    logic [3:0]       row_n_q,     row_n_d;
    logic             busy_q,      busy_d;
`ifdef KEY_REPEAT_EN
    localparam int RP_W = $clog2(REPEAT_SCANS + 1);
    logic [RP_W-1:0]  rep_q,       rep_d;
`endif

    logic       sample;
    logic       one_hot_low;
    logic [1:0] col_idx_s;
    logic       db_done;

    assign sample  = (div_q == DIV_W'(SCAN_DIV - 1));
    assign db_done = (db_cnt_q == DB_W'(DEBOUNCE_CNT));

    // Only a single low column is a valid press; anything else is ghosting.
    always_comb begin
        one_hot_low = 1'b1;
        col_idx_s   = 2'd0;
        case (col_s)
            3'b110:  col_idx_s = 2'd0;
            3'b101:  col_idx_s = 2'd1;
            3'b011:  col_idx_s = 2'd2;
            default: one_hot_low = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        div_d      = sample ? '0 : div_q + DIV_W'(1);
        row_idx_d  = row_idx_q;
        col_idx_d  = col_idx_q;
        col_pat_d  = col_pat_q;
        db_cnt_d   = db_cnt_q;
        key_code_d = KEY_NONE;
`ifdef KEY_REPEAT_EN
        rep_d      = rep_q;
`endif

        case (state_q)
            SCAN: begin
                if (sample) begin
                    if (one_hot_low) begin
                        col_pat_d = col_s;
                        col_idx_d = col_idx_s;
                        db_cnt_d  = DB_W'(1);
                        state_d   = DEBOUNCE;
                    end else begin
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end
            end
            DEBOUNCE: begin
                if (db_done) begin
                    key_code_d = key_map(row_idx_q, col_idx_q);
                    db_cnt_d   = '0;
                    state_d    = HELD;
`ifdef KEY_REPEAT_EN
                    rep_d      = '0;
`endif
                end else if (sample) begin
                    if (col_s == col_pat_q) begin
                        db_cnt_d = db_cnt_q + DB_W'(1);
                    end else begin
                        db_cnt_d  = '0;
                        row_idx_d = row_idx_q + 2'd1;
                        state_d   = SCAN;
                    end
                end
            end
            HELD: begin
                if (db_done) begin
                    db_cnt_d  = '0;
                    row_idx_d = 2'd0;
                    state_d   = SCAN;
                end else if (sample) begin
                    db_cnt_d = (col_s == 3'b111) ? db_cnt_q + DB_W'(1) : '0;
`ifdef KEY_REPEAT_EN
                    if (col_s == col_pat_q) begin
                        if (rep_q == RP_W'(REPEAT_SCANS - 1)) begin
                            key_code_d = key_map(row_idx_q, col_idx_q);
                            rep_d      = '0;
                        end else begin
                            rep_d = rep_q + RP_W'(1);
                        end
                    end else begin
                        rep_d = '0;
                    end
`endif
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase

        row_n_d = ~(4'b0001 << row_idx_d);
        busy_d  = (state_d != SCAN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SCAN;
            div_q      <= '0;
            row_idx_q  <= 2'd0;
            col_idx_q  <= 2'd0;
            col_pat_q  <= 3'b111;
            db_cnt_q   <= '0;
            key_code_q <= KEY_NONE;
            row_n_q    <= 4'b1110;
            busy_q     <= 1'b0;
`ifdef KEY_REPEAT_EN
            rep_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            row_idx_q  <= row_idx_d;
            col_idx_q  <= col_idx_d;
            col_pat_q  <= col_pat_d;
            db_cnt_q   <= db_cnt_d;
            key_code_q <= key_code_d;
            row_n_q    <= row_n_d;
            busy_q     <= busy_d;
`ifdef KEY_REPEAT_EN
            rep_q      <= rep_d;
`endif
        end
    end

    assign row_n    = row_n_q;
    assign key_code = key_code_q;
    assign busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// ============================================================================
// Module   : tb_keypad_scanner
// Purpose  : Directed self-checking bench for keypad_scanner with a keypad
//            model that shorts a pressed key's column to its row line.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_keypad_scanner;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 3;
    localparam int REPEAT_SCANS = 5;

    logic       clk;
    logic       rst;
    logic [2:0] col_n;
    logic [3:0] row_n;
    logic [3:0] key_code;
    logic       busy;

    logic [11:0] keys;
    logic [3:0]  ev[$];
    logic        prev_hit;
    logic        consec_bad;
    logic        row_bad;
    logic        busy_seen;
    logic [3:0]  r0;
    int          errors;
    int          checks;
    logic [3:0]  exp_rows [4];

    keypad_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT),
        .REPEAT_SCANS (REPEAT_SCANS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .col_n    (col_n),
        .row_n    (row_n),
        .key_code (key_code),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key index is row*3 + col.
    always_comb begin
        col_n = 3'b111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (keys[r*3+c] && !row_n[r]) col_n[c] = 1'b0;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (key_code != 4'd13) begin
                ev.push_back(key_code);
                if (prev_hit) consec_bad = 1'b1;
                prev_hit = 1'b1;
            end else begin
                prev_hit = 1'b0;
            end
            if (!(row_n inside {4'b1110, 4'b1101, 4'b1011, 4'b0111})) row_bad = 1'b1;
            if (busy) busy_seen = 1'b1;
        end else begin
            prev_hit = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ev(input int n, input int budget);
        for (int k = 0; k < budget && ev.size() < n; k++) cyc(1);
    endtask

    function automatic logic [3:0] ev_at(input int i);
        return (ev.size() > i) ? ev[i] : 4'd15;
    endfunction

    initial begin
        errors     = 0;
        checks     = 0;
        keys       = '0;
        prev_hit   = 1'b0;
        consec_bad = 1'b0;
        row_bad    = 1'b0;
        busy_seen  = 1'b0;
        exp_rows   = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        rst        = 1'b1;
        cyc(3);
        rst = 1'b0;

        // Idle scanning
        check("reset_row_n", row_n, 4'b1110);
        check("reset_key_code", key_code, 13);
        check("reset_busy", busy, 0);
        for (int i = 1; i <= 16; i++) begin
            cyc(4);
            check("idle_row_rotation", row_n, exp_rows[i % 4]);
        end
        check("idle_no_codes", ev.size(), 0);
        check("idle_busy_never", busy_seen, 0);

        // '6' held steady
        keys[5] = 1'b1;
        wait_ev(1, 200);
        check("six_code", ev_at(0), 6);
        check("six_busy", busy, 1);
        check("six_row", row_n, 4'b1101);
        cyc(12);
        check("six_single", ev.size(), 1);
        check("six_row_held", row_n, 4'b1101);
        keys = '0;
        cyc(60);
        check("six_release_busy", busy, 0);
        ev.delete();

        // '#' then '*'
        keys[11] = 1'b1;
        wait_ev(1, 200);
        keys = '0;
        cyc(60);
        keys[9] = 1'b1;
        wait_ev(2, 200);
        keys = '0;
        cyc(60);
        check("hash_star_count", ev.size(), 2);
        check("hash_code", ev_at(0), 10);
        check("star_code", ev_at(1), 11);
        ev.delete();

        // '5' bouncing on alternate samples, then stable
        for (int i = 0; i < 20; i++) begin
            keys[4] = (i % 2 == 0);
            cyc(4);
        end
        check("bounce_no_code", ev.size(), 0);
        keys[4] = 1'b1;
        wait_ev(1, 200);
        cyc(8);
        check("bounce_count", ev.size(), 1);
        check("bounce_code", ev_at(0), 5);
        keys = '0;
        cyc(60);
        ev.delete();

        // '1' and '3' together: ghost, no code
        keys[0] = 1'b1;
        keys[2] = 1'b1;
        busy_seen = 1'b0;
        cyc(80);
        check("multi_no_code", ev.size(), 0);
        check("multi_no_busy", busy_seen, 0);
        r0 = row_n;
        cyc(4);
        check("multi_scan_continues", row_n != r0, 1);
        keys = '0;
        cyc(20);

        // '2' pressed while '8' held
        keys[7] = 1'b1;
        wait_ev(1, 200);
        check("eight_code", ev_at(0), 8);
        keys[1] = 1'b1;
        cyc(12);
        check("two_ignored", ev.size(), 1);
        keys = '0;
        cyc(60);
        check("eight_two_total", ev.size(), 1);
        ev.delete();

        // Reset during debounce of '9'
        keys[8] = 1'b1;
        for (int k = 0; k < 200 && !busy; k++) cyc(1);
        check("nine_debounce_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("nine_rst_key_code", key_code, 13);
        check("nine_rst_row_n", row_n, 4'b1110);
        check("nine_rst_busy", busy, 0);
        cyc(2);
        rst = 1'b0;
        check("nine_no_partial", ev.size(), 0);
        wait_ev(1, 200);
        cyc(8);
        check("nine_count", ev.size(), 1);
        check("nine_code", ev_at(0), 9);
        keys = '0;
        cyc(60);
        ev.delete();

        // '0' held long
        keys[10] = 1'b1;
        wait_ev(1, 200);
        cyc(90);
`ifdef KEY_REPEAT_EN
        check("zero_repeat_count", ev.size(), 5);
        check("zero_repeat_last", ev_at(4), 0);
`else
        check("zero_single_count", ev.size(), 1);
`endif
        check("zero_code", ev_at(0), 0);
        keys = '0;
        cyc(60);

        check("no_consecutive_codes", consec_bad, 0);
        check("row_n_one_low", row_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Matrix-keypad front end that produces the 4-bit key-code stream consumed by the safe controller's `invalue` input.
- Scans a 4-row x 3-column keypad by driving one row low at a time and sampling the columns.
- Debounces presses and releases.
- For each debounced press, outputs exactly one single-cycle key code; at all other times it outputs the idle code 13.

Parameters:
- SCAN_DIV, 1000, clk cycles each row is driven before its columns are sampled; must be >= 4.
- DEBOUNCE_CNT, 8, consecutive identical samples needed to accept a press or a release; must be >= 1.
- REPEAT_SCANS, 256, samples between auto-repeat codes; used only when KEY_REPEAT_EN is defined.

Ports:
- clk  input  1  system clock
- rst  input  1  reset
- col_n  input  3  keypad columns, active-low, externally pulled up, asynchronous to clk
- row_n  output  4  keypad row drive, active-low, exactly one bit low at any time
- key_code  output  4  0-9 digit, 10 '#', 11 '*', 13 no key; non-13 for exactly one cycle per event
- busy  output  1  high while a key is being debounced or is held

Interface: reset rst, asynchronous, active-high; clock clk.

Behaviour:
- Key map, row r / column c:
  - r0 = 1 2 3
  - r1 = 4 5 6
  - r2 = 7 8 9
  - r3 = * 0 # (codes 11, 0, 10)
- Reset values:
  - row_n = 4'b1110
  - key_code = 13
  - busy = 0
  - state = SCAN
  - row index = 0, dwell counter = 0, debounce counter = 0
- Column input:
  - col_n passes through a 2-flop synchronizer.
  - A "sample" is the synchronized column value taken when the dwell counter equals SCAN_DIV-1.
  - The dwell counter then wraps to 0.
  - The counter runs continuously in every state.
- SCAN state:
  - On each sample, a one-hot low column means candidate column c on the current row r: latch (r,c), set debounce counter = 1, go to DEBOUNCE. The row is not advanced.
  - No column low, or more than one column low (ghosting or multi-key): advance the row index modulo 4 and update row_n on the same edge.
- DEBOUNCE state:
  - Row r stays driven.
  - A sample equal to the latched one-hot pattern increments the counter.
  - When the counter reaches DEBOUNCE_CNT: drive key_code = map(r,c) for one cycle, go to HELD, clear the counter.
  - Any differing sample returns to SCAN and advances the row.
  - Latency: when DEBOUNCE_CNT = 1, the code is emitted on the cycle after the first qualifying sample.
- HELD state:
  - Row r stays driven; key_code = 13.
  - Each all-high sample increments the release counter.
  - Any non-all-high sample clears the release counter. A different key pressed on the same row is ignored; there is no second code until release.
  - When the release counter reaches DEBOUNCE_CNT: go to SCAN with row index 0.
- busy = 1 in DEBOUNCE and HELD, 0 in SCAN.
- A key held through reset is re-detected from SCAN as a fresh press after reset deasserts.
- An asynchronous reset mid-debounce or mid-hold discards all progress; no partial code is ever emitted.
- key_code is registered; it is never asserted in two consecutive cycles.

Optional Feature:
- KEY_REPEAT_EN defined:
  - In HELD, a sample counter counts samples while the latched pattern remains asserted.
  - Each time it reaches REPEAT_SCANS, emit map(r,c) again for one cycle and clear the counter.
  - A release sample or a changed pattern clears the counter.
  - '#' and '*' also repeat.
- KEY_REPEAT_EN undefined:
  - Exactly one code per press.
  - No repeat counter logic is synthesized; REPEAT_SCANS is ignored.

Decomposition:
- Package keypad_pkg holds:
  - constants KEY_HASH = 4'd10, KEY_STAR = 4'd11, KEY_NONE = 4'd13
  - the state enum {SCAN, DEBOUNCE, HELD}
  - a function key_map(row, col) returning the 4-bit code
- Sub-module sync_2ff (width parameter) for the col_n synchronizer; it is reusable for other asynchronous pins.

Test Plan (SCAN_DIV = 4, DEBOUNCE_CNT = 3, keypad model ties a pressed key's column to its row line):
- Reset, no keys pressed for 64 cycles -> row_n cycles 1110, 1101, 1011, 0111 every 4 cycles; key_code is 13 throughout; busy = 0.
- Press r1c2 ('6') held steady -> after 3 matching samples key_code = 6 for exactly one cycle; busy = 1; row_n holds 1101 until release.
- Press r3c2 ('#'), then r3c0 ('*'), each followed by a release of 3+ samples -> codes 10 then 11, one cycle each, with 13 between them.
- Bounce: '5' toggles on alternate samples for 20 samples, then settles pressed -> no code during bouncing; exactly one code 5 after 3 stable samples.
- Two keys '1' and '3' pressed together on row 0 -> no code emitted; scanning continues. Press '2' while '8' is held -> no code for '2'.
- Assert rst during DEBOUNCE of '9' -> key_code = 13 and row_n = 1110 immediately. After deassert with '9' still held -> one code 9.
- KEY_REPEAT_EN defined, REPEAT_SCANS = 5, '0' held for 20 samples after acceptance -> code 0 emitted at acceptance, then 4 more times at 5-sample spacing.
